// File: rtl/sipo_pkg.sv
// Shared definitions for the serial/parallel converters: bit-order selectors
// and the counter-width helper, so the serialiser can reuse them later.
package sipo_pkg;

   // Bit-order selectors for the LSB_FIRST parameter.
   localparam bit ORDER_LSB_FIRST = 1'b1;
   localparam bit ORDER_MSB_FIRST = 1'b0;

   // Width needed to hold a bit position in 0..width.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Serial shift register plus bit counter. Presents the word as it will look
// after the current shift (word) so that the completing bit is included
// when word_done fires. WIDTH must be at least 2.
module sipo_shift_core
   import sipo_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = ORDER_LSB_FIRST,
   localparam int CW       = cnt_width(WIDTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             shift_en,
   input  logic             serial_in,
   input  logic             clear,
   output logic [WIDTH-1:0] word,
   output logic             word_done,
   output logic [CW-1:0]    bit_count
);

   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] sr_next;
   logic             last_bit;

   // LSB-first: new bits enter at the top and walk down, so the first bit
   // received ends in bit 0. MSB-first: the mirror image.
   if (LSB_FIRST == ORDER_LSB_FIRST) begin : g_lsb
      assign sr_next = {serial_in, sr[WIDTH-1:1]};
   end else begin : g_msb
      assign sr_next = {sr[WIDTH-2:0], serial_in};
   end

   assign last_bit = (bit_count == LAST_BIT);

   // Completion strobe; clear suppresses it so a flushed word never escapes.
   always_comb begin
      word_done = 1'b0;
      word      = sr_next;
      if (shift_en && last_bit && !clear) begin
         word_done = 1'b1;
      end
   end

   // Shift register: clear flushes, otherwise shift on enable.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sr <= '0;
      end else if (clear) begin
         sr <= '0;
      end else if (shift_en) begin
         sr <= sr_next;
      end
   end

   // Bit counter: wraps to 0 on the completing shift so the next word starts clean.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bit_count <= '0;
      end else if (clear) begin
         bit_count <= '0;
      end else if (shift_en) begin
         if (last_bit) begin
            bit_count <= '0;
         end else begin
            bit_count <= bit_count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserialiser with a one-word holding register and a
// valid/ready output handshake. A word completing while the holding register
// is still occupied (and not being drained this cycle) is dropped and flagged
// on the sticky overrun output.
module sipo_deserializer
   import sipo_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = ORDER_LSB_FIRST,
   localparam int CW       = cnt_width(WIDTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             shift_en,
   input  logic             serial_in,
   input  logic             clear,
   input  logic             out_ready,
   output logic [WIDTH-1:0] parallel_out,
   output logic             out_valid,
   output logic [CW-1:0]    bit_count,
   output logic             overrun
);

   logic [WIDTH-1:0] word;
   logic             word_done;
   logic             take;
   logic             hold_free;

   sipo_shift_core #(
      .WIDTH     (WIDTH),
      .LSB_FIRST (LSB_FIRST)
   ) u_core (
      .clock     (clock),
      .reset     (reset),
      .shift_en  (shift_en),
      .serial_in (serial_in),
      .clear     (clear),
      .word      (word),
      .word_done (word_done),
      .bit_count (bit_count)
   );

   // Holding register can accept a new word if empty or being drained now.
   assign take      = out_valid & out_ready;
   assign hold_free = ~out_valid | out_ready;

   // Holding register: loaded only on an accepted completion; clear leaves it alone.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         parallel_out <= '0;
      end else if (word_done && hold_free) begin
         parallel_out <= word;
      end
   end

   // Valid flag: set by an accepted completion, dropped by a transfer; a
   // completion on the transfer edge keeps it high with the new word.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
      end else if (clear) begin
         out_valid <= 1'b0;
      end else if (word_done && hold_free) begin
         out_valid <= 1'b1;
      end else if (take) begin
         out_valid <= 1'b0;
      end
   end

   // Sticky overrun: a completed word arrived with the holding register blocked.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         overrun <= 1'b0;
      end else if (clear) begin
         overrun <= 1'b0;
      end else if (word_done && !hold_free) begin
         overrun <= 1'b1;
      end
   end

endmodule
